// File: rtl/serial_twos_negator_pkg.sv
// Shared definitions for the bit-serial two's complement negator:
// FSM state encoding and the default operand width.
package serial_twos_negator_pkg;

    localparam int NEG_DEFAULT_N = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } neg_state_t;

endpackage

// File: rtl/serial_twos_negator_if.sv
// Handshake/data bundle for serial_twos_negator.
//   in_valid/in_ready/R            : operand side (producer -> block)
//   out_valid/out_ready/B/zero/ovf : result side (block -> consumer)
//   busy                           : block is not in IDLE
// slave  : the negator itself
// master : the environment driving operands and consuming results
interface serial_twos_negator_if
    import serial_twos_negator_pkg::*;
#(
    parameter int N = NEG_DEFAULT_N
) ();

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] R;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] B;
    logic         zero;
    logic         ovf;
    logic         busy;

    modport master (
        output in_valid, R, out_ready,
        input  in_ready, out_valid, B, zero, ovf, busy
    );

    modport slave (
        input  in_valid, R, out_ready,
        output in_ready, out_valid, B, zero, ovf, busy
    );

endinterface

// File: rtl/serial_twos_negator_half_adder.sv
// Single-bit half adder used as the time-shared bit engine.
//   A, B : addend bits
//   Sum  : A xor B
//   Cout : A and B
module HalfAdder (
    input  logic A,
    input  logic B,
    output logic Sum,
    output logic Cout
);

    assign Sum  = A ^ B;
    assign Cout = A & B;

endmodule

// File: rtl/serial_twos_negator.sv
// Bit-serial two's complement negator (B = ~R + 1), LSB first, one bit
// per clock through a single HalfAdder.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : slave side of serial_twos_negator_if (operand/result
//          handshakes, zero = final carry, ovf = most-negative operand,
//          busy = not IDLE)
module serial_twos_negator
    import serial_twos_negator_pkg::*;
#(
    parameter int N = NEG_DEFAULT_N
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_twos_negator_if.slave bus
);

    localparam int CW = $clog2(N);

    neg_state_t    state;
    logic [CW-1:0] cnt;
    logic          carry;
    logic [N-1:0]  op_sr;
    logic [N-1:0]  res_sr;
    logic          msb_in;
    logic [N-1:0]  b_q;
    logic          zero_q;
    logic          ovf_q;

    logic ha_sum;
    logic ha_cout;

    HalfAdder u_ha (
        .A    (~op_sr[0]),
        .B    (carry),
        .Sum  (ha_sum),
        .Cout (ha_cout)
    );

    // Handshake flags depend only on registered state.
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.B         = b_q;
    assign bus.zero      = zero_q;
    assign bus.ovf       = ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            carry  <= 1'b1;
            op_sr  <= '0;
            res_sr <= '0;
            msb_in <= 1'b0;
            b_q    <= '0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_sr  <= bus.R;
                        carry  <= 1'b1;
                        cnt    <= '0;
                        res_sr <= '0;
                        msb_in <= bus.R[N-1];
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    res_sr <= {ha_sum, res_sr[N-1:1]};
                    op_sr  <= op_sr >> 1;
                    carry  <= ha_cout;
                    if (cnt == CW'(N - 1)) begin
                        // Output registers load the final bit directly so
                        // B/zero/ovf are valid in the first DONE cycle;
                        // the MSB carry goes only to zero, never into B.
                        b_q    <= {ha_sum, res_sr[N-1:1]};
                        zero_q <= ha_cout;
                        ovf_q  <= msb_in & ha_sum;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        zero_q <= 1'b0;
                        ovf_q  <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_twos_negator.sv
// Self-checking bench for serial_twos_negator (N = 8): directed vector
// table, backpressure, input-ignore and mid-operation reset sequences,
// then random operands with random out_ready.
module tb_serial_twos_negator;
    import serial_twos_negator_pkg::*;

    localparam int N = 8;

    typedef struct {
        logic [7:0] r;
        logic [7:0] exp_b;
        logic       exp_zero;
        logic       exp_ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int errors = 0;
    int checks = 0;
    int acc_cnt = 0;
    int hs_cnt = 0;

    always #5 clk = ~clk;

    serial_twos_negator_if #(.N(N)) bus ();

    serial_twos_negator #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always @(posedge clk) begin
        if (!rst) begin
            if (bus.in_valid && bus.in_ready) acc_cnt++;
            if (bus.out_valid && bus.out_ready) hs_cnt++;
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one operand; return when out_valid is seen (or bound expires).
    task automatic do_op(input logic [7:0] r, output logic [7:0] b,
                         output logic z, output logic o, output int lat);
        int guard;
        guard = 0;
        while (!bus.in_ready && guard < 50) begin
            tick();
            guard++;
        end
        check("accept_ready", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.R = r;
        tick();
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 50) begin
            tick();
            lat++;
        end
        b = bus.B;
        z = bus.zero;
        o = bus.ovf;
    endtask

    vec_t vecs[8];

    initial begin
        logic [7:0] b;
        logic       z;
        logic       o;
        int         lat;
        int         a0;
        bit         saw_valid;

        vecs[0] = '{8'h05, 8'hFB, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h80, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'hFF, 8'h01, 1'b0, 1'b0};
        vecs[4] = '{8'h01, 8'hFF, 1'b0, 1'b0};
        vecs[5] = '{8'h7F, 8'h81, 1'b0, 1'b0};
        vecs[6] = '{8'h12, 8'hEE, 1'b0, 1'b0};
        vecs[7] = '{8'h81, 8'h7F, 1'b0, 1'b0};

        bus.in_valid  = 1'b0;
        bus.R         = '0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_B", 32'(bus.B), 32'd0);
        check("rst_zero", 32'(bus.zero), 32'd0);
        check("rst_ovf", 32'(bus.ovf), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);

        // Directed table, no backpressure.
        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].r, b, z, o, lat);
            check("vec_B", 32'(b), 32'(vecs[i].exp_b));
            check("vec_zero", 32'(z), 32'(vecs[i].exp_zero));
            check("vec_ovf", 32'(o), 32'(vecs[i].exp_ovf));
            check("vec_latency", 32'(lat), 32'd8);
            check("vec_in_ready_done", 32'(bus.in_ready), 32'd0);
            tick();
            check("vec_in_ready_after", 32'(bus.in_ready), 32'd1);
            check("vec_out_valid_after", 32'(bus.out_valid), 32'd0);
            check("vec_zero_idle", 32'(bus.zero), 32'd0);
            check("vec_ovf_idle", 32'(bus.ovf), 32'd0);
            check("vec_B_held", 32'(bus.B), 32'(vecs[i].exp_b));
        end

        // Backpressure: result held while out_ready is low.
        bus.out_ready = 1'b0;
        do_op(8'h7F, b, z, o, lat);
        check("stall_B", 32'(b), 32'h81);
        check("stall_latency", 32'(lat), 32'd8);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("stall_out_valid", 32'(bus.out_valid), 32'd1);
            check("stall_B_stable", 32'(bus.B), 32'h81);
            check("stall_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        tick();
        check("stall_release_idle", 32'(bus.in_ready), 32'd1);
        check("stall_release_ov", 32'(bus.out_valid), 32'd0);

        // Input activity during SHIFT must be ignored.
        a0 = acc_cnt;
        bus.in_valid = 1'b1;
        bus.R = 8'h3C;
        tick();
        for (int k = 0; k < 8; k++) begin
            bus.in_valid = ~bus.in_valid;
            bus.R = 8'hAA;
            check("ignore_busy", 32'(bus.busy), 32'd1);
            tick();
        end
        bus.in_valid = 1'b0;
        check("ignore_out_valid", 32'(bus.out_valid), 32'd1);
        check("ignore_B", 32'(bus.B), 32'hC4);
        tick();
        check("ignore_single_accept", 32'(acc_cnt - a0), 32'd1);

        // Reset during SHIFT cycle 4 aborts the operation.
        bus.in_valid = 1'b1;
        bus.R = 8'h12;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        tick();
        check("abort_in_shift", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_B", 32'(bus.B), 32'd0);
        saw_valid = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (bus.out_valid) saw_valid = 1'b1;
            tick();
        end
        check("abort_no_out_valid", 32'(saw_valid), 32'd0);
        do_op(8'h01, b, z, o, lat);
        check("post_abort_B", 32'(b), 32'hFF);
        check("post_abort_zero", 32'(z), 32'd0);
        tick();

        // Random operands with random backpressure.
        for (int i = 0; i < 1000; i++) begin
            logic [7:0] r;
            logic [7:0] nr;
            logic [9:0] got;
            int         g;
            bit         done;
            r = 8'($urandom_range(0, 255));
            if (i % 50 == 0) r = 8'h00;
            if (i % 50 == 1) r = 8'h80;
            nr = 8'((256 - int'(r)) % 256);
            g = 0;
            while (!bus.in_ready && g < 50) begin
                tick();
                g++;
            end
            bus.in_valid = 1'b1;
            bus.R = r;
            tick();
            bus.in_valid = 1'b0;
            bus.R = 8'($urandom_range(0, 255));
            done = 1'b0;
            got = '0;
            g = 0;
            while (!done && g < 100) begin
                bus.out_ready = 1'($urandom_range(0, 1));
                if (bus.out_valid && bus.out_ready) begin
                    got = {bus.B, bus.zero, bus.ovf};
                    done = 1'b1;
                end
                tick();
                g++;
            end
            check("rand_done", 32'(done), 32'd1);
            check("rand_result", 32'(got), 32'({nr, (r == 8'h00), (r == 8'h80)}));
        end
        bus.out_ready = 1'b1;
        tick();

        check("handshake_count", 32'(hs_cnt), 32'(acc_cnt - 1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
